// File: rtl/uart_pkg.sv
// UART peripheral shared definitions:
// register map, status/control bit positions, FSM states.
package uart_pkg;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_RXDATA = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_TXEMPTY = 0;
  localparam int ST_TXFULL  = 1;
  localparam int ST_RXEMPTY = 2;
  localparam int ST_OVR     = 3;
  localparam int ST_FERR    = 4;
  localparam int ST_TXOVF   = 5;
  localparam int ST_TXBUSY  = 6;
  localparam int ST_RXBUSY  = 7;

  localparam int CT_IE_W    = 5;
  localparam int CT_TXFLUSH = 8;
  localparam int CT_RXFLUSH = 9;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush; a push while full
// is accepted only when a pop frees a slot that cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == NW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + NW'(1);
      else if (!do_push && do_pop)
        count <= count - NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART with TX/RX FIFOs, sticky
// error flags and a level interrupt.
module uart_fifo_periph
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrtEn,
  input  logic        rdEn,
  input  logic [1:0]  addr,
  input  logic [31:0] WrData,
  input  logic        SerialIn,
  output logic [31:0] ReadReg,
  output logic        SerialOut,
  output logic        IrqOut
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  logic wr_tx, wr_stat, wr_ctrl, rx_pop;
  assign wr_tx   = wrtEn && (addr == ADDR_TXDATA);
  assign wr_stat = wrtEn && (addr == ADDR_STATUS);
  assign wr_ctrl = wrtEn && (addr == ADDR_CTRL);
  assign rx_pop  = rdEn && (addr == ADDR_RXDATA);

  logic                 tx_push, tx_pop, tx_flush;
  logic                 tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_dout;
  logic [NW-1:0]        tx_count;
  logic                 rx_push, rx_flush;
  logic                 rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_dout;
  logic [NW-1:0]        rx_count;

  assign tx_push  = wr_tx && !tx_full;
  assign tx_flush = wr_ctrl && WrData[CT_TXFLUSH];
  assign rx_flush = wr_ctrl && WrData[CT_RXFLUSH];

  tx_state_t            tx_state, tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_bit, tx_tick;

  rx_state_t            rx_state, rx_next;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_s1, rx_s2, rx_s3;
  logic                 rx_fall, rx_half, rx_tick;
  logic                 ferr_set;

  uart_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (WrData[DATA_BITS-1:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  uart_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rx_shreg),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // ---- TX ----
  assign tx_tick = (tx_cnt == BIT_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shreg  <= '0;
      SerialOut <= 1'b1;
    end else begin
      tx_state  <= tx_next;
      SerialOut <= tx_bit;
      if (tx_pop) begin
        tx_shreg <= tx_dout;
        tx_cnt   <= '0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_tick) begin
          tx_cnt <= '0;
          if (tx_state == TX_START)
            tx_idx <= '0;
          if (tx_state == TX_DATA) begin
            tx_shreg <= tx_shreg >> 1;
            tx_idx   <= tx_idx + IW'(1);
          end
        end else begin
          tx_cnt <= tx_cnt + CW'(1);
        end
      end
    end
  end

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    unique case (tx_state)
      TX_IDLE:
        if (!tx_empty) begin
          tx_next = TX_START;
          tx_pop  = 1'b1;
        end
      TX_START:
        if (tx_tick) tx_next = TX_DATA;
      TX_DATA:
        if (tx_tick && tx_idx == LAST_BIT)
          tx_next = TX_STOP;
      TX_STOP:
        if (tx_tick) begin
          // chain straight into the next frame
          tx_next = tx_empty ? TX_IDLE : TX_START;
          tx_pop  = !tx_empty;
        end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    unique case (tx_state)
      TX_START: tx_bit = 1'b0;
      TX_DATA:  tx_bit = tx_shreg[0];
      default:  tx_bit = 1'b1;
    endcase
  end

  // ---- RX ----
  assign rx_fall = rx_s3 && !rx_s2;
  assign rx_half = (rx_cnt == HALF_END);
  assign rx_tick = (rx_cnt == BIT_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shreg <= '0;
    end else begin
      rx_s1    <= SerialIn;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_next;
      if (rx_state == RX_IDLE) begin
        rx_cnt <= '0;
        rx_idx <= '0;
      end else if ((rx_state == RX_START && rx_half) || rx_tick) begin
        rx_cnt <= '0;
        if (rx_state == RX_DATA) begin
          rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
          rx_idx   <= rx_idx + IW'(1);
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    rx_next  = rx_state;
    rx_push  = 1'b0;
    ferr_set = 1'b0;
    unique case (rx_state)
      RX_IDLE:
        if (rx_fall) rx_next = RX_START;
      RX_START:
        if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (rx_tick && rx_idx == LAST_BIT)
          rx_next = RX_STOP;
      RX_STOP:
        if (rx_tick) begin
          rx_next  = RX_IDLE;
          rx_push  = rx_s2;
          ferr_set = !rx_s2;
        end
      default: rx_next = RX_IDLE;
    endcase
  end

  // ---- registers ----
  logic                 ovr, ferr, txovf, ovr_set;
  logic [CT_IE_W-1:0]   ctrl_ie;
  logic [CT_IE_W-1:0]   irq_src;
  logic [7:0]           rx_level;
  logic [31:0]          status;
  logic                 unused_bits;

  assign ovr_set  = rx_push && rx_full && !rx_pop;
  assign irq_src  = {ferr, ovr, !rx_empty, tx_full, tx_empty};
  assign rx_level = 8'(rx_count);
  assign status   = {16'b0, rx_level,
                     rx_state != RX_IDLE, tx_state != TX_IDLE,
                     txovf, ferr, ovr, rx_empty, tx_full, tx_empty};
  assign unused_bits = ^{WrData, tx_count};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr     <= 1'b0;
      ferr    <= 1'b0;
      txovf   <= 1'b0;
      ctrl_ie <= '0;
      IrqOut  <= 1'b0;
    end else begin
      ovr   <= ovr_set || (ovr && !(wr_stat && WrData[ST_OVR]));
      ferr  <= ferr_set || (ferr && !(wr_stat && WrData[ST_FERR]));
      txovf <= (wr_tx && tx_full) ||
               (txovf && !(wr_stat && WrData[ST_TXOVF]));
      if (wr_ctrl)
        ctrl_ie <= WrData[CT_IE_W-1:0];
      IrqOut <= |(irq_src & ctrl_ie);
    end
  end

  always_comb begin
    ReadReg = '0;
    unique case (1'b1)
      (addr == ADDR_TXDATA): ReadReg = '0;
      (addr == ADDR_RXDATA): ReadReg = rx_empty ? '0 : 32'(rx_dout);
      (addr == ADDR_STATUS): ReadReg = status;
      (addr == ADDR_CTRL):   ReadReg = 32'(ctrl_ie);
      default:               ReadReg = '0;
    endcase
  end

endmodule
